// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Display word layout and the anode-select helper live here.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [6:0]  SEG_OFF    = 7'b1111111;
  localparam logic [3:0]  AN_OFF     = 4'b1111;
  localparam logic [3:0]  BLANK_CODE = 4'hF;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
  } disp_t;

  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// BCD to active-low segment decoder, {g,f,e,d,c,b,a} ordering.
// Codes 10-15 turn every segment off.
module seven_segment_decoder (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a frame-aligned
// double buffer, ghost blanking and leading-zero suppression.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick,
  output logic        pending
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  disp_t            shadow_q, shadow_d;
  disp_t            disp_q, disp_d;
  logic             pending_q, pending_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;
  logic             tick_q, tick_d;

  logic       cnt_end;
  logic       frame_end;
  disp_t      in_val;
  logic [3:0] lz_blank;
  logic [3:0] raw_nib;
  logic [3:0] nib;
  logic [6:0] dec_seg;

  always_comb begin
    cnt_end   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_end = cnt_end && (idx_q == 2'd3);
    cnt_d     = cnt_end ? '0 : cnt_q + CNT_W'(1);
    idx_d     = cnt_end ? idx_q + 2'd1 : idx_q;
  end

  // A load landing on the frame-end cycle bypasses straight into disp.
  always_comb begin
    in_val    = '{bcd: bcd_in, dp: dp_in};
    shadow_d  = load ? in_val : shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (frame_end) begin
      pending_d = 1'b0;
      if (load)
        disp_d = in_val;
      else if (pending_q)
        disp_d = shadow_q;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    lz_blank[3] = blank_lz && (disp_q.bcd[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (disp_q.bcd[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (disp_q.bcd[7:4] == 4'd0);
    lz_blank[0] = 1'b0;
    raw_nib     = disp_q.bcd[idx_q*4 +: 4];
    nib         = lz_blank[idx_q] ? BLANK_CODE : raw_nib;
  end

  seven_segment_decoder u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  always_comb begin
    seg_d  = dec_seg;
    dp_d   = ~disp_q.dp[idx_q];
    an_d   = (cnt_q >= CNT_W'(BLANK_CYC)) ? an_sel(idx_q) : AN_OFF;
    tick_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
      an_q      <= AN_OFF;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      tick_q    <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;
  assign pending    = pending_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display. It holds a 4-digit BCD value and steps one shared `seven_segment_decoder` across the digits, driving one anode at a time. Each slot starts with a ghost-suppression blanking interval. New values are double-buffered and committed only at frame boundaries, so a display never tears mid-scan. It sits between the lab datapath, which produces BCD results, and the top-level segment/anode pins.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ 2.
- `BLANK_CYC`, 16: cycles at the start of each slot with all anodes off; must be < `REFRESH_DIV`.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset; synchronous and active-low.
- `load`  in  1  single-cycle strobe; capture `bcd_in` and `dp_in`.
- `bcd_in`  in  16  four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `dp_in`  in  4  decimal point enable per digit, active-high.
- `blank_lz`  in  1  leading-zero blanking enable, sampled every cycle.
- `seg`  out  7  segment cathodes, active-low, registered.
- `dp`  out  1  decimal point cathode, active-low, registered.
- `an`  out  4  anodes, active-low, at most one low, registered.
- `frame_tick`  out  1  one-cycle pulse at the end of each frame.
- `pending`  out  1  a loaded value is waiting for the next frame boundary.

## Operation
- **Slot counter:** `cnt` counts 0..`REFRESH_DIV`-1.
  - At terminal count, `cnt` returns to 0 and the digit index `idx` advances 0→1→2→3→0.
  - `cnt` width is `$clog2(REFRESH_DIV)`.
- **Double buffering:** there are two registers, `shadow` (16+4 bits) and `disp` (16+4 bits).
  - When `load` is high, `shadow` captures `bcd_in` and `dp_in`, and `pending` goes to 1.
  - Repeated loads before the boundary overwrite `shadow`; the last one wins.
- **Frame end:** the cycle with `idx`==3 and `cnt`==`REFRESH_DIV`-1.
  - If `pending`, then `disp` ← `shadow` and `pending` ← 0.
  - `frame_tick` pulses on the following cycle whether or not a commit happened.
- **Load on the frame-end cycle:** `disp` takes `bcd_in`/`dp_in` directly (bypass), `shadow` also captures them, and `pending` stays 0.
- **Digit nibble selection:** the nibble for `idx` goes to the decoder, with these rules:
  - If `blank_lz`=1, digit k (k=3,2,1) is blank when it and every higher digit are 0. Digit 0 is never zero-blanked.
  - Blank is encoded as nibble 4'hF, which the decoder maps to all segments off.
  - Nibbles 10–15 in `disp` display blank (decoder default).
- **Decimal point:** `dp` = ~`disp.dp[idx]`, independent of digit blanking.
- **Anodes:** `an[idx]` is low only when `cnt` ≥ `BLANK_CYC`. During the guard interval, `an`=4'b1111; `seg` and `dp` still carry the new digit.

## Timing
- **Reset values** (cycle after `rst_n` sampled low):
  - outputs: `an`=4'b1111, `seg`=7'b1111111, `dp`=1, `frame_tick`=0, `pending`=0.
  - internal state: `cnt`=0, `idx`=0, `shadow`=0, `disp`=0.
- **Output latency:** `seg`, `dp` and `an` are registered functions of the current (`idx`, `cnt`, `disp`), so there is one-cycle latency.
  - `an` goes low on the cycle after `cnt` first equals `BLANK_CYC`.
  - `an` returns to 4'b1111 on the cycle after `cnt` wraps to 0.
- **Load to display:**
  - A value is visible on digit 0 starting at the first frame boundary after the load.
  - Worst case is 4·`REFRESH_DIV`+1 cycles from load.
- **Reset mid-frame:** state is restored to the reset values immediately; any pending load is discarded. The frame restarts at digit 0.
- **Reset priority:** `rst_n` low overrides `load` in the same cycle.

## Structure
- **Shared package `seg_pkg`:**
  - `NUM_DIGITS`=4
  - `SEG_OFF`=7'b1111111
  - `AN_OFF`=4'b1111
  - `BLANK_CODE`=4'hF
- **Sub-module:** one instance of the existing `seven_segment_decoder` (combinational). Its output is registered in this block to form `seg`.
- **Remaining RTL:** slot/digit counter, double-buffer control, leading-zero mask logic, output registers.

## Test plan
Use `REFRESH_DIV`=8 and `BLANK_CYC`=2 unless stated.
- **Reset:** hold `rst_n`=0 for 3 cycles, then release.
  - During reset: `an`=1111, `seg`=1111111, `dp`=1, `pending`=0.
  - After release: `an`=1110 appears on cycle 3 with `seg`=1000000 (digit 0 shows "0").
- **Scan order:** run 2 frames with `disp`=16'h1234.
  - `an` sequence is 1110, 1101, 1011, 0111, each low for 6 cycles, separated by 2 cycles of 1111.
  - `seg` per digit: 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1).
  - `frame_tick` pulses every 32 cycles.
- **Double buffer:** load 16'h5678 mid-slot 1.
  - `pending`=1 until frame end.
  - The current frame still shows the old value.
  - The next frame's digit 0 shows `seg`=0000000 (8).
- **Boundary and overwrite:**
  - Load on the exact frame-end cycle: the new value is displayed next frame and `pending` stays 0.
  - Two loads in one frame: only the second is displayed.
- **Leading-zero blanking:** `blank_lz`=1 with 16'h0050.
  - Digits 3 and 2 show 1111111; digit 1 shows 5; digit 0 shows 0.
  - With 16'h0000, only digit 0 is lit.
  - With nibble 4'hA: that digit shows blank.
- **Reset mid-operation:** assert `rst_n`=0 during slot 2 with `pending`=1.
  - Outputs return to reset values and `pending`=0.
  - After release, the display shows 0000.
